mdio_burst_read_ctrl: RTL and testbench



---
 rtl/mdio_burst_read_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_mdio_burst_read_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_burst_read_ctrl.sv
// Burst read sequencer for the MDIO memory path: credit-limited single-word issue into a small output FIFO.
// Build option MDIO_BURST_ADDR_WRAP_EN: wrap the address at MEM_DEPTH-1 and run the full length instead of truncating.
module mdio_burst_read_ctrl #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MEM_DEPTH  = 32768
) (
  input  logic        clk_200m,
  input  logic        rst_200m,
  input  logic        cmd_start,
  input  logic [6:0]  cmd_mem_sel,
  input  logic [14:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic        cmd_abort,
  output logic        busy,
  output logic        done,
  output logic        trunc,
  output logic        mdio_rd_en,
  output logic        rf_mdio_read_en,
  output logic [6:0]  rf_mdio_which_memory_sel,
  output logic [14:0] rf_mdio_memory_addr,
  input  logic [8:0]  rf_mdio_pkt_data,
  output logic [8:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] word_cnt
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LAST_ADDR = 15'(MEM_DEPTH - 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    trunc_q, trunc_d;
  logic                    mdio_rd_en_q, mdio_rd_en_d;
  logic                    read_en_q, read_en_d;
  logic [6:0]              sel_q, sel_d;
  logic [14:0]             addr_out_q, addr_out_d;
  logic [14:0]             cur_addr_q, cur_addr_d;
  logic [15:0]             remaining_q, remaining_d;
  logic [15:0]             word_cnt_q, word_cnt_d;
  logic [RD_LATENCY-1:0]   infl_q, infl_d;

  logic [8:0]              mem_q [FIFO_DEPTH];
  logic [8:0]              mem_d [FIFO_DEPTH];
  ptr_t                    wr_ptr_q, wr_ptr_d;
  ptr_t                    rd_ptr_q, rd_ptr_d;
  cnt_t                    fifo_cnt_q, fifo_cnt_d;

  logic [31:0]             pending;
  logic                    can_issue;
  logic                    push;
  logic                    pop;
  logic                    accept;

  // Words already committed to the FIFO: the registered strobe plus every stage of the return pipe.
  always_comb begin
    pending = 32'(read_en_q);
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      pending = pending + 32'(infl_q[i]);
    end
  end

  assign can_issue = (32'(fifo_cnt_q) + pending) < 32'(FIFO_DEPTH);
  assign push      = infl_q[RD_LATENCY-1];
  assign pop       = (fifo_cnt_q != '0) && rd_ready;
  assign accept    = (state_q == S_IDLE) && cmd_start && !cmd_abort;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    trunc_d      = trunc_q;
    mdio_rd_en_d = mdio_rd_en_q;
    read_en_d    = 1'b0;
    sel_d        = sel_q;
    addr_out_d   = addr_out_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;

    infl_d[0] = read_en_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      infl_d[i] = infl_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          sel_d       = cmd_mem_sel;
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          trunc_d     = 1'b0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = S_RUN;
            busy_d       = 1'b1;
            mdio_rd_en_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (can_issue) begin
          read_en_d   = 1'b1;
          addr_out_d  = cur_addr_q;
          remaining_d = remaining_q - 16'd1;
          if (cur_addr_q == LAST_ADDR) begin
`ifdef MDIO_BURST_ADDR_WRAP_EN
            cur_addr_d = '0;
`else
            if (remaining_q > 16'd1) begin
              trunc_d = 1'b1;
            end
            remaining_d = '0;
`endif
          end else begin
            cur_addr_d = cur_addr_q + 15'd1;
          end
          if (remaining_d == '0) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Window stays open until the final word has been captured.
        if (pending == '0) begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          mdio_rd_en_d = 1'b0;
          done_d       = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cmd_abort) begin
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      mdio_rd_en_d = 1'b0;
      read_en_d    = 1'b0;
      infl_d       = '0;
    end

    word_cnt_d = (accept ? 16'd0 : word_cnt_q) + 16'(pop);
  end

  // Output FIFO; a push into a full FIFO is only ever paired with a pop, so head data is read before overwrite.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = rf_mdio_pkt_data;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (cmd_abort) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_200m) begin
    if (rst_200m) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trunc_q      <= 1'b0;
      mdio_rd_en_q <= 1'b0;
      read_en_q    <= 1'b0;
      sel_q        <= '0;
      addr_out_q   <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      word_cnt_q   <= '0;
      infl_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trunc_q      <= trunc_d;
      mdio_rd_en_q <= mdio_rd_en_d;
      read_en_q    <= read_en_d;
      sel_q        <= sel_d;
      addr_out_q   <= addr_out_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      word_cnt_q   <= word_cnt_d;
      infl_q       <= infl_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      mem_q        <= mem_d;
    end
  end

  assign busy                     = busy_q;
  assign done                     = done_q;
  assign trunc                    = trunc_q;
  assign mdio_rd_en               = mdio_rd_en_q;
  assign rf_mdio_read_en          = read_en_q;
  assign rf_mdio_which_memory_sel = sel_q;
  assign rf_mdio_memory_addr      = addr_out_q;
  assign rd_data                  = mem_q[rd_ptr_q];
  assign rd_valid                 = (fifo_cnt_q != '0);
  assign word_cnt                 = word_cnt_q;

endmodule

// File: tb/tb_mdio_burst_read_ctrl.sv
// Bench for mdio_burst_read_ctrl: directed and random bursts against a word-list reference model.
// Honours MDIO_BURST_ADDR_WRAP_EN when computing the expected address sequence.
`timescale 1ns/1ps
module tb_mdio_burst_read_ctrl;

  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MEM_DEPTH  = 32768;

  logic        clk_200m = 1'b0;
  logic        rst_200m = 1'b1;
  logic        cmd_start = 1'b0;
  logic [6:0]  cmd_mem_sel = '0;
  logic [14:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_abort = 1'b0;
  logic        busy, done, trunc, mdio_rd_en, rf_mdio_read_en;
  logic [6:0]  rf_mdio_which_memory_sel;
  logic [14:0] rf_mdio_memory_addr;
  logic [8:0]  rf_mdio_pkt_data;
  logic [8:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] word_cnt;

  mdio_burst_read_ctrl #(
    .RD_LATENCY(RD_LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk_200m                (clk_200m),
    .rst_200m                (rst_200m),
    .cmd_start               (cmd_start),
    .cmd_mem_sel             (cmd_mem_sel),
    .cmd_addr                (cmd_addr),
    .cmd_len                 (cmd_len),
    .cmd_abort               (cmd_abort),
    .busy                    (busy),
    .done                    (done),
    .trunc                   (trunc),
    .mdio_rd_en              (mdio_rd_en),
    .rf_mdio_read_en         (rf_mdio_read_en),
    .rf_mdio_which_memory_sel(rf_mdio_which_memory_sel),
    .rf_mdio_memory_addr     (rf_mdio_memory_addr),
    .rf_mdio_pkt_data        (rf_mdio_pkt_data),
    .rd_data                 (rd_data),
    .rd_valid                (rd_valid),
    .rd_ready                (rd_ready),
    .word_cnt                (word_cnt)
  );

  always #2.5 clk_200m = ~clk_200m;

  function automatic logic [8:0] pkt(input logic [6:0] sel, input logic [14:0] addr);
    return addr[8:0] ^ {sel[6:3], 5'b0};
  endfunction

  // Downstream read stage: data valid RD_LATENCY cycles after a strobe, zero while the window is closed.
  logic        p_en   [RD_LATENCY];
  logic [14:0] p_addr [RD_LATENCY];
  logic [6:0]  p_sel  [RD_LATENCY];

  always @(posedge clk_200m) begin
    p_en[0]   <= rf_mdio_read_en;
    p_addr[0] <= rf_mdio_memory_addr;
    p_sel[0]  <= rf_mdio_which_memory_sel;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      p_en[i]   <= p_en[i-1];
      p_addr[i] <= p_addr[i-1];
      p_sel[i]  <= p_sel[i-1];
    end
  end

  assign rf_mdio_pkt_data = !mdio_rd_en ? 9'h000 :
                            (p_en[RD_LATENCY-1] === 1'b1) ? pkt(p_sel[RD_LATENCY-1], p_addr[RD_LATENCY-1]) : 9'h1AB;

  int          errors = 0;
  int          checks = 0;
  logic [14:0] exp_addr [$];
  logic [6:0]  exp_sel = '0;
  logic        exp_trunc = 1'b0;
  int          issue_idx = 0;
  int          pop_idx = 0;
  int          done_cnt = 0;
  int          run_len = 0;
  int          first_run = 0;
  bit          first_run_done = 1'b0;
  bit          mdio_seen = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Per-cycle observation of the issue side, the consumer side and the outstanding-word bound.
  task automatic monitor();
    if (rf_mdio_read_en === 1'b1) begin
      checks++;
      assert (issue_idx < exp_addr.size()) else begin
        errors++;
        $error("FAIL extra_issue: observed issue %0d expected at most %0d", issue_idx + 1, exp_addr.size());
      end
      if (issue_idx < exp_addr.size()) chk("issue_addr", 32'(rf_mdio_memory_addr), 32'(exp_addr[issue_idx]));
      issue_idx++;
      run_len++;
    end else begin
      if (run_len != 0 && !first_run_done) begin
        first_run      = run_len;
        first_run_done = 1'b1;
      end
      run_len = 0;
    end
    if (busy === 1'b1) chk("mem_sel_held", 32'(rf_mdio_which_memory_sel), 32'(exp_sel));
    if (mdio_rd_en === 1'b1) mdio_seen = 1'b1;
    if (done === 1'b1) done_cnt++;
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      checks++;
      assert (pop_idx < exp_addr.size()) else begin
        errors++;
        $error("FAIL extra_word: observed word %0d expected at most %0d", pop_idx + 1, exp_addr.size());
      end
      if (pop_idx < exp_addr.size()) chk("rd_data", 32'(rd_data), 32'(pkt(exp_sel, exp_addr[pop_idx])));
      pop_idx++;
    end
    checks++;
    assert (issue_idx - pop_idx <= int'(FIFO_DEPTH)) else begin
      errors++;
      $error("FAIL overflow: observed outstanding %0d expected <= %0d", issue_idx - pop_idx, FIFO_DEPTH);
    end
  endtask

  task automatic step();
    @(negedge clk_200m);
    monitor();
    @(posedge clk_200m);
    #1;
    if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_burst(input logic [6:0] sel, input logic [14:0] addr, input logic [15:0] len);
    logic [14:0] a;
    exp_addr.delete();
    exp_trunc = 1'b0;
    a = addr;
    for (int k = 0; k < int'(len); k++) begin
      exp_addr.push_back(a);
      if (int'(a) == int'(MEM_DEPTH) - 1) begin
`ifdef MDIO_BURST_ADDR_WRAP_EN
        a = '0;
`else
        if (k < int'(len) - 1) exp_trunc = 1'b1;
        break;
`endif
      end else begin
        a = a + 15'd1;
      end
    end
    exp_sel = sel; issue_idx = 0; pop_idx = 0; done_cnt = 0;
    run_len = 0; first_run = 0; first_run_done = 1'b0; mdio_seen = 1'b0;
    cmd_mem_sel = sel; cmd_addr = addr; cmd_len = len; cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(len != 16'd0));
    chk("done_after_start", 32'(done), 32'(len == 16'd0));
  endtask

  task automatic finish_burst(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || rd_valid !== 1'b0) && n < budget) begin
      if (busy === 1'b0) begin
        rand_ready = 1'b0;
        rd_ready   = 1'b1;
      end
      step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL burst_timeout: observed %0d cycles expected < %0d", n, budget);
    end
    rand_ready = 1'b0;
    rd_ready   = 1'b1;
    step();
    step();
    chk("issue_count", 32'(issue_idx), 32'(exp_addr.size()));
    chk("word_count", 32'(pop_idx), 32'(exp_addr.size()));
    chk("word_cnt", 32'(word_cnt), 32'(exp_addr.size()));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("trunc", 32'(trunc), 32'(exp_trunc));
    chk("mdio_rd_en_seen", 32'(mdio_seen), 32'(exp_addr.size() != 0));
    chk("mdio_rd_en_idle", 32'(mdio_rd_en), 32'd0);
  endtask

  initial begin
    int n;
    logic [14:0] ra;

    // Reset values
    rst_200m = 1'b1;
    step(); step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trunc", 32'(trunc), 32'd0);
    chk("rst_mdio_rd_en", 32'(mdio_rd_en), 32'd0);
    chk("rst_read_en", 32'(rf_mdio_read_en), 32'd0);
    chk("rst_sel", 32'(rf_mdio_which_memory_sel), 32'd0);
    chk("rst_addr", 32'(rf_mdio_memory_addr), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst_200m = 1'b0;
    step();

    // Full-throughput burst: credit limits the first run of strobes to FIFO_DEPTH
    rd_ready = 1'b1;
    start_burst(7'd5, 15'h0010, 16'd8);
    finish_burst(200);
    chk("first_run_len", 32'(first_run), 32'(FIFO_DEPTH));

    // Consumer stalled: issue stops once the FIFO plus in-flight words reach FIFO_DEPTH
    rd_ready = 1'b0;
    start_burst(7'd3, 15'h0200, 16'd6);
    for (int i = 0; i < 12; i++) step();
    chk("stall_issue_count", 32'(issue_idx), 32'(FIFO_DEPTH));
    chk("stall_rd_valid", 32'(rd_valid), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    rd_ready = 1'b1;
    finish_burst(200);

    // Zero-length command
    start_burst(7'd7, 15'h0040, 16'd0);
    finish_burst(20);

    // Top-of-memory boundary
    start_burst(7'd2, 15'h7FFE, 16'd4);
    finish_burst(200);

    // Reset while idle clears the sticky status
    rst_200m = 1'b1;
    step();
    chk("rst_idle_trunc", 32'(trunc), 32'd0);
    chk("rst_idle_word_cnt", 32'(word_cnt), 32'd0);
    rst_200m = 1'b0;
    step();

    // Start pulsed mid-burst is ignored
    start_burst(7'd5, 15'h0100, 16'd12);
    step(); step(); step();
    cmd_mem_sel = 7'd9; cmd_addr = 15'h0555; cmd_len = 16'd3; cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("ignored_start_sel", 32'(rf_mdio_which_memory_sel), 32'd5);
    chk("ignored_start_busy", 32'(busy), 32'd1);
    finish_burst(300);

    // Abort after ten issues, then a clean burst
    start_burst(7'd4, 15'h1000, 16'd100);
    n = 0;
    while (issue_idx < 10 && n < 200) begin
      step();
      n++;
    end
    chk("abort_reach_10", 32'(issue_idx >= 10), 32'd1);
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mdio_rd_en", 32'(mdio_rd_en), 32'd0);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_read_en", 32'(rf_mdio_read_en), 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    start_burst(7'd6, 15'h2000, 16'd5);
    finish_burst(200);

    // Reset in the middle of a burst
    start_burst(7'd1, 15'h0300, 16'd20);
    for (int i = 0; i < 8; i++) step();
    rst_200m = 1'b1;
    step();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_mdio_rd_en", 32'(mdio_rd_en), 32'd0);
    chk("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_mid_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_mid_trunc", 32'(trunc), 32'd0);
    rst_200m = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Random bursts with a randomly stalling consumer, half of them near the top of memory
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) ra = 15'(int'(MEM_DEPTH) - 1 - int'($urandom_range(0, 8)));
      else ra = 15'($urandom_range(0, 32767));
      rand_ready = 1'b1;
      start_burst(7'($urandom_range(0, 95)), ra, 16'($urandom_range(0, 12)));
      finish_burst(400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
